seat_access_scheduler: RTL

// Serialises seat transactions from N_KIOSK kiosks and one manager console onto the single

---
 rtl/seat_access_if.sv | 37 +++
 rtl/seat_access_scheduler.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/seat_access_if.sv
// Kiosk/manager request side and memory-facing outputs of the seat access scheduler.
// master = requester side (kiosks, console, memory observer), slave = scheduler.
interface seat_access_if #(
   parameter int unsigned N_KIOSK = 4
) ();
   logic [N_KIOSK-1:0]    req;
   logic [32*N_KIOSK-1:0] req_student;
   logic [5*N_KIOSK-1:0]  req_seat;
   logic [2*N_KIOSK-1:0]  req_state;
   logic [N_KIOSK-1:0]    gnt;
   logic                  mgr_req;
   logic [1:0]            mgr_cmd;
   logic [1:0]            mgr_ban;
   logic [10:0]           mgr_limit;
   logic                  mgr_gnt;
   logic                  write_mem;
   logic [31:0]           Student_No_mem;
   logic [4:0]            Seat_No_mem;
   logic [1:0]            Seat_State_mem;
   logic [1:0]            write_set_mem;
   logic [10:0]           limit_time_mem;
   logic [1:0]            ban_mem;
   logic [10:0]           Time_mem;
   logic                  is_open;

   modport master (
      output req, req_student, req_seat, req_state, mgr_req, mgr_cmd, mgr_ban, mgr_limit,
      input  gnt, mgr_gnt, write_mem, Student_No_mem, Seat_No_mem, Seat_State_mem,
             write_set_mem, limit_time_mem, ban_mem, Time_mem, is_open
   );

   modport slave (
      input  req, req_student, req_seat, req_state, mgr_req, mgr_cmd, mgr_ban, mgr_limit,
      output gnt, mgr_gnt, write_mem, Student_No_mem, Seat_No_mem, Seat_State_mem,
             write_set_mem, limit_time_mem, ban_mem, Time_mem, is_open
   );
endinterface

// File: rtl/seat_access_scheduler.sv
// Serialises kiosk and manager transactions onto the seat-table write port, keeps the
// minute-of-day clock and the manager configuration registers.
module seat_access_scheduler #(
   parameter int unsigned N_KIOSK       = 4,
   parameter int unsigned TICKS_PER_MIN = 60,
   parameter int unsigned OPEN_TIME     = 360,
   parameter int unsigned CLOSE_TIME    = 1380,
   parameter int unsigned LIMIT_DEFAULT = 120
) (
   input logic         clk,
   input logic         rst_mem,
   seat_access_if.slave bus
);
   localparam int unsigned IdxW  = (N_KIOSK > 1) ? $clog2(N_KIOSK) : 1;
   localparam int unsigned TickW = $clog2(TICKS_PER_MIN);

   typedef enum logic [1:0] {StIdle, StIssue, StGap} state_e;

   state_e            state_q, state_d;
   logic [TickW-1:0]  tick_q;
   logic [10:0]       time_q;
   logic [IdxW-1:0]   rr_q, sel_q;
   logic              is_mgr_q;
   logic [1:0]        cmd_q, ban_q, sstate_q;
   logic [10:0]       limit_q;
   logic [31:0]       student_q;
   logic [4:0]        seat_q;

   logic [31:0]       stu_a [N_KIOSK];
   logic [4:0]        seat_a [N_KIOSK];
   logic [1:0]        st_a [N_KIOSK];
   logic              pick_valid, is_open, load_mgr, load_kiosk, issue;
   logic [IdxW-1:0]   pick_idx, cand;

   assign is_open = (time_q >= 11'(OPEN_TIME)) && (time_q < 11'(CLOSE_TIME));

   always_comb begin
      for (int k = 0; k < int'(N_KIOSK); k++) begin
         stu_a[k]  = bus.req_student[k*32 +: 32];
         seat_a[k] = bus.req_seat[k*5 +: 5];
         st_a[k]   = bus.req_state[k*2 +: 2];
      end
   end

   // Scan from the farthest offset down so the nearest requester at/after rr_q wins.
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int i = int'(N_KIOSK) - 1; i >= 0; i--) begin
         cand = IdxW'((int'(rr_q) + i) % int'(N_KIOSK));
         if (bus.req[cand]) begin
            pick_valid = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      load_mgr   = 1'b0;
      load_kiosk = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.mgr_req) begin
               load_mgr = 1'b1;
               state_d  = StIssue;
            end else if (is_open && pick_valid) begin
               load_kiosk = 1'b1;
               state_d    = StIssue;
            end
         end
         StIssue: state_d = StGap;
         StGap:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst_mem) begin
      if (rst_mem) state_q <= StIdle;
      else         state_q <= state_d;
   end

   // Minute clock runs independently of the FSM.
   always_ff @(posedge clk or posedge rst_mem) begin
      if (rst_mem) begin
         tick_q <= '0;
         time_q <= 11'(OPEN_TIME);
      end else if (tick_q == TickW'(TICKS_PER_MIN - 1)) begin
         tick_q <= '0;
         time_q <= (time_q == 11'd1439) ? 11'd0 : time_q + 11'd1;
      end else begin
         tick_q <= tick_q + TickW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst_mem) begin
      if (rst_mem) begin
         rr_q      <= '0;
         sel_q     <= '0;
         is_mgr_q  <= 1'b0;
         cmd_q     <= 2'd0;
         ban_q     <= 2'd2;
         limit_q   <= 11'(LIMIT_DEFAULT);
         student_q <= '0;
         seat_q    <= '0;
         sstate_q  <= '0;
      end else begin
         if (load_mgr) begin
            is_mgr_q <= 1'b1;
            cmd_q    <= bus.mgr_cmd;
            if (bus.mgr_cmd == 2'd1) ban_q <= bus.mgr_ban;
            if (bus.mgr_cmd == 2'd2) limit_q <= bus.mgr_limit;
         end
         if (load_kiosk) begin
            is_mgr_q  <= 1'b0;
            sel_q     <= pick_idx;
            student_q <= stu_a[pick_idx];
            seat_q    <= seat_a[pick_idx];
            sstate_q  <= st_a[pick_idx];
         end
         if (issue && !is_mgr_q) begin
            rr_q <= (sel_q == IdxW'(N_KIOSK - 1)) ? '0 : sel_q + IdxW'(1);
         end
      end
   end

   assign issue = (state_q == StIssue);

   always_comb begin
      bus.gnt = '0;
      if (issue && !is_mgr_q) bus.gnt[sel_q] = 1'b1;
   end

   assign bus.write_mem      = issue && !is_mgr_q;
   assign bus.mgr_gnt        = issue && is_mgr_q;
   // Illegal commands are acknowledged but never strobed.
   assign bus.write_set_mem  = (issue && is_mgr_q && (cmd_q == 2'd1 || cmd_q == 2'd2))
                               ? cmd_q : 2'd0;
   assign bus.Student_No_mem = student_q;
   assign bus.Seat_No_mem    = seat_q;
   assign bus.Seat_State_mem = sstate_q;
   assign bus.limit_time_mem = limit_q;
   assign bus.ban_mem        = ban_q;
   assign bus.Time_mem       = time_q;
   assign bus.is_open        = is_open;
endmodule
